// File: rtl/rob_sn_alloc.sv
`default_nettype none
// ============================================================================
// Module      : rob_sn_alloc
// Description : In-order sequence-number allocator for rob_OpCentricQueue.
//               Hands out ROB slot indices 0..p_depth-1 in program order,
//               wrapping explicitly at p_depth-1, and reclaims the oldest
//               outstanding slot whenever the ROB retires its front entry.
//               No SN is reissued while it is still outstanding.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   p_depth     number of ROB entries (>= 2), must match the ROB instance
//   p_ptrwidth  SN width, must match the ROB's p_ptrwidth
// Ports:
//   clk          sole clock, all state updates on posedge
//   rst          synchronous active-low reset
//   alloc_req_i  requester wants one SN this cycle
//   alloc_gnt_o  SN granted this cycle (combinational)
//   alloc_sn_o   SN being granted (tail pointer)
//   free_en_i    ROB front entry retired this cycle (deq_front_cpl)
//   head_sn_o    oldest outstanding SN (ROB dequeue pointer)
//   count_o      number of outstanding SNs, 0..p_depth
//   full_o       count_o == p_depth
//   empty_o      count_o == 0
//   err_o        sticky underflow flag (free while empty)
// Configuration macro:
//   ROB_SN_ALLOC_BYPASS_EN  when defined, a same-cycle free lets an
//                           allocation proceed while full.
// ============================================================================
module rob_sn_alloc #(
  parameter int p_depth    = 32,
  parameter int p_ptrwidth = $clog2(p_depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req_i,
  output logic                  alloc_gnt_o,
  output logic [p_ptrwidth-1:0] alloc_sn_o,
  input  logic                  free_en_i,
  output logic [p_ptrwidth-1:0] head_sn_o,
  output logic [p_ptrwidth:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  err_o
);

  localparam logic [p_ptrwidth-1:0] c_last  = p_ptrwidth'(p_depth - 1);
  localparam logic [p_ptrwidth:0]   c_depth = (p_ptrwidth + 1)'(p_depth);
  localparam logic [p_ptrwidth-1:0] c_one_p = p_ptrwidth'(1);
  localparam logic [p_ptrwidth:0]   c_one_c = (p_ptrwidth + 1)'(1);

  logic [p_ptrwidth-1:0] tail_q, tail_d;
  logic [p_ptrwidth-1:0] head_q, head_d;
  logic [p_ptrwidth:0]   count_q, count_d;
  logic                  err_q, err_d;

  logic w_full;
  logic w_empty;
  logic w_gnt;
  logic w_free_ok;

  assign w_full  = (count_q == c_depth);
  assign w_empty = (count_q == '0);

  // A free on an empty allocator is an underflow: it is flagged but moves
  // nothing, so head/count stay consistent with the ROB.
  assign w_free_ok = free_en_i && !w_empty;

`ifdef ROB_SN_ALLOC_BYPASS_EN
  // When full, the slot retiring this cycle is handed straight back out.
  // Since p_depth >= 2, full implies non-empty, so that free is always valid.
  assign w_gnt = rst && alloc_req_i && (!w_full || free_en_i);
`else
  assign w_gnt = rst && alloc_req_i && !w_full;
`endif

  always_comb begin
    tail_d  = tail_q;
    head_d  = head_q;
    count_d = count_q;
    err_d   = err_q;

    // Explicit wrap so non-power-of-two depths stay within 0..p_depth-1.
    if (w_gnt) begin
      tail_d = (tail_q == c_last) ? '0 : tail_q + c_one_p;
    end

    if (w_free_ok) begin
      head_d = (head_q == c_last) ? '0 : head_q + c_one_p;
    end

    case ({w_gnt, w_free_ok})
      2'b10:   count_d = count_q + c_one_c;
      2'b01:   count_d = count_q - c_one_c;
      default: count_d = count_q;
    endcase

    if (free_en_i && w_empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tail_q  <= '0;
      head_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      tail_q  <= tail_d;
      head_q  <= head_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign alloc_gnt_o = w_gnt;
  assign alloc_sn_o  = tail_q;
  assign head_sn_o   = head_q;
  assign count_o     = count_q;
  assign full_o      = w_full;
  assign empty_o     = w_empty;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rob_sn_alloc.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_sn_alloc
// Description : Self-checking bench for rob_sn_alloc (p_depth = 8). A queue
//               of outstanding SNs serves as the reference; directed
//               scenarios are pinned with literal expectations, followed by
//               randomized traffic with occasional resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_sn_alloc;

  localparam int c_depth = 8;
  localparam int c_pw    = $clog2(c_depth);
`ifdef ROB_SN_ALLOC_BYPASS_EN
  localparam bit c_byp = 1'b1;
`else
  localparam bit c_byp = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            req = 1'b0;
  logic            fre = 1'b0;
  logic            alloc_gnt;
  logic [c_pw-1:0] alloc_sn;
  logic [c_pw-1:0] head_sn;
  logic [c_pw:0]   count;
  logic            full;
  logic            empty;
  logic            err;

  rob_sn_alloc #(
    .p_depth    (c_depth),
    .p_ptrwidth (c_pw)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_req_i (req),
    .alloc_gnt_o (alloc_gnt),
    .alloc_sn_o  (alloc_sn),
    .free_en_i   (fre),
    .head_sn_o   (head_sn),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // Reference model: outstanding SNs in issue order, next SN to hand out,
  // sticky underflow flag.
  int q[$];
  int nsn  = 0;
  bit merr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  int obs_gnt;
  int obs_sn;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, compare all outputs against the
  // model once the combinational grant has settled, then advance the model
  // at the posedge.
  task automatic step(input bit r, input bit a, input bit f);
    bit exp_gnt;
    int exp_head;
    @(negedge clk);
    rst = r;
    req = a;
    fre = f;
    #1;
    exp_gnt  = r && a && ((q.size() < c_depth) || (c_byp && f));
    exp_head = (q.size() > 0) ? q[0] : nsn;
    chk("gnt",   int'(alloc_gnt), int'(exp_gnt));
    chk("sn",    int'(alloc_sn),  nsn);
    chk("count", int'(count),     q.size());
    chk("full",  int'(full),      int'(q.size() == c_depth));
    chk("empty", int'(empty),     int'(q.size() == 0));
    chk("head",  int'(head_sn),   exp_head);
    chk("err",   int'(err),       int'(merr));
    obs_gnt = int'(alloc_gnt);
    obs_sn  = int'(alloc_sn);
    @(posedge clk);
    if (!r) begin
      q.delete();
      nsn  = 0;
      merr = 1'b0;
    end else begin
      if (f && q.size() == 0) merr = 1'b1;
      if (f && q.size() > 0) void'(q.pop_front());
      if (exp_gnt) begin
        q.push_back(nsn);
        nsn = (nsn + 1) % c_depth;
      end
    end
  endtask

  // Let registered outputs settle after the posedge, without crossing an edge.
  task automatic peek();
    #2;
  endtask

  initial begin
    // Reset
    step(0, 0, 0);
    step(0, 0, 0);
    peek();
    chk("lit_rst_count", int'(count), 0);
    chk("lit_rst_empty", int'(empty), 1);
    chk("lit_rst_full",  int'(full),  0);
    chk("lit_rst_err",   int'(err),   0);

    // Three grants in order
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0);
      chk("lit_first_gnt", obs_gnt, 1);
      chk("lit_first_sn",  obs_sn,  i);
    end
    peek();
    chk("lit_3_count", int'(count),   3);
    chk("lit_3_head",  int'(head_sn), 0);
    chk("lit_3_empty", int'(empty),   0);

    // Fill to 8, then a denied 9th request
    for (int i = 3; i < 8; i++) step(1, 1, 0);
    peek();
    chk("lit_full",      int'(full),  1);
    chk("lit_full_cnt",  int'(count), 8);
    step(1, 1, 0);
    chk("lit_9th_gnt", obs_gnt, 0);
    chk("lit_9th_sn",  obs_sn,  0);

    // Free from full together with a request
    step(1, 1, 1);
    if (c_byp) begin
      chk("lit_byp_gnt", obs_gnt, 1);
      chk("lit_byp_sn",  obs_sn,  0);
      peek();
      chk("lit_byp_count", int'(count),   8);
      chk("lit_byp_head",  int'(head_sn), 1);
    end else begin
      chk("lit_nb_gnt_same", obs_gnt, 0);
      peek();
      chk("lit_nb_count", int'(count),   7);
      chk("lit_nb_head",  int'(head_sn), 1);
      step(1, 1, 0);
      chk("lit_nb_gnt_next", obs_gnt, 1);
      chk("lit_nb_sn_next",  obs_sn,  0);
    end

    // Wrap-around: reset, then 20 grants with a free every cycle after the first
    step(0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, i > 0);
      chk("lit_wrap_sn", obs_sn, i % 8);
    end
    peek();
    chk("lit_wrap_count", int'(count), 1);
    chk("lit_wrap_err",   int'(err),   0);

    // Underflow: drain, then free while empty
    step(1, 0, 1);
    step(1, 0, 1);
    peek();
    chk("lit_uf_err",   int'(err),     1);
    chk("lit_uf_count", int'(count),   0);
    chk("lit_uf_head",  int'(head_sn), 4);
    for (int i = 0; i < 10; i++) step(1, ($urandom & 1) != 0, ($urandom & 1) != 0);
    peek();
    chk("lit_uf_sticky", int'(err), 1);

    // Reset mid-operation with count = 5 and both req/free high
    step(0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0);
    peek();
    chk("lit_pre_rst_count", int'(count), 5);
    step(0, 1, 1);
    chk("lit_rst_gnt", obs_gnt, 0);
    peek();
    chk("lit_post_rst_count", int'(count),    0);
    chk("lit_post_rst_head",  int'(head_sn),  0);
    chk("lit_post_rst_sn",    int'(alloc_sn), 0);
    chk("lit_post_rst_err",   int'(err),      0);

    // Randomized traffic, biased per phase toward filling or draining
    for (int p = 0; p < 8; p++) begin
      int req_pct = (p % 2 == 0) ? 80 : 30;
      int fre_pct = (p % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 60; i++) begin
        step($urandom_range(0, 99) != 0,
             $urandom_range(0, 99) < req_pct,
             $urandom_range(0, 99) < fre_pct);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
